// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types and helpers for the UART blocks.
//   - uart_rx_state_t : receiver FSM state encoding
//   - PARITY_*        : values accepted by the PARITY parameter
//   - uart_div()      : system clocks per oversample tick, shared with the
//                       transmitter so both ends derive the same divider
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } uart_rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Integer division: the residual baud error is accepted by design.
  function automatic int uart_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if
//   Received-word delivery channel of the UART receiver: one-entry
//   valid/ready holding register with per-word error flags.
//   Signals:
//     rx_data    received word, LSB = first bit on the line
//     rx_valid   rx_data and the flags are valid
//     rx_ready   consumer accepts the word when rx_valid && rx_ready
//     frame_err  stop bit sampled 0 (qualified by rx_valid)
//     parity_err parity mismatch (qualified by rx_valid)
//     overrun    one-cycle pulse when a completed frame was dropped
//   Modports: master = receiver side, slave = consumer side.
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output parity_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  parity_err,
    input  overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
//   Free-running divider producing the oversample tick.
//   The counter runs 0..DIV-1 and wraps; tick is high for the single cycle
//   in which the counter sits at DIV-1. Only reset clears it.
//   Ports:
//     clk   system clock
//     reset synchronous, active-high
//     tick  one-cycle strobe every DIV clocks
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : g_bad_div
    $error("uart_baud_tick: DIV must be >= 1");
  end

  logic [CW-1:0] cnt_q;
  logic          wrap;

  assign wrap = (cnt_q == CW'(DIV - 1));
  assign tick = wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (wrap) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core
//   Parametrised UART receiver with majority-vote sampling, false-start
//   rejection, optional parity, 1 or 2 stop bits and break handling.
//   Completed words go to a one-entry valid/ready holding register.
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high
//     rxd    asynchronous serial line, idle high
//     rx     delivery channel (uart_rx_core_if master): rx_data, rx_valid,
//            rx_ready, frame_err, parity_err, overrun
//     busy   receiver is not idle
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rxd,
  uart_rx_core_if.master   rx,
  output logic             busy
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2;
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS + 1);

  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_core: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be >= 1");
  end
  if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4) begin : g_bad_os
    $error("uart_rx_core: OVERSAMPLE must be even and >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_rx_core: DATA_BITS must be 5..9");
  end
  if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_par
    $error("uart_rx_core: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_core: STOP_BITS must be 1 or 2");
  end

  // Input synchroniser; both flops idle high so reset never fakes a start.
  logic rx_meta_q;
  logic rxs;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs       <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rxs       <= rx_meta_q;
    end
  end

  logic tick;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  uart_rx_state_t       state_q;
  uart_rx_state_t       state_n;
  logic [SCW-1:0]       sc_q;
  logic [BCW-1:0]       bit_cnt_q;
  logic                 stop_cnt_q;
  logic                 v0_q;
  logic                 v1_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 fe_acc_q;
  logic                 pe_acc_q;

  logic at_vote;
  logic sc_last;
  logic maj;
  logic fe_final;
  logic par_bad;
  logic last_bit;
  logic last_stop;
  logic done;

  // The third vote sample is the live rxs at the MID+1 tick, so the
  // majority is available in the same cycle it is needed.
  assign at_vote   = tick && (sc_q == SCW'(MID + 1));
  assign sc_last   = tick && (sc_q == SCW'(OVERSAMPLE - 1));
  assign maj       = (v0_q & v1_q) | (v0_q & rxs) | (v1_q & rxs);
  assign fe_final  = fe_acc_q | ~maj;
  assign par_bad   = (^shreg_q) ^ maj ^ (PARITY == PARITY_ODD);
  assign last_bit  = (bit_cnt_q == BCW'(DATA_BITS - 1));
  assign last_stop = (STOP_BITS == 1) || stop_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    done    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (tick && !rxs) state_n = RX_START;
      end
      RX_START: begin
        if (at_vote && maj)  state_n = RX_IDLE;
        else if (sc_last)    state_n = RX_DATA;
      end
      RX_DATA: begin
        if (sc_last && last_bit) begin
          state_n = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (sc_last) state_n = RX_STOP;
      end
      RX_STOP: begin
        // Complete at the last stop vote rather than at the end of the bit
        // so the next start edge can be caught even with a short stop bit.
        if (at_vote && last_stop) begin
          done    = 1'b1;
          state_n = (shreg_q == '0 && fe_final) ? RX_BREAK : RX_IDLE;
        end
      end
      RX_BREAK: begin
        if (rxs) state_n = RX_IDLE;
      end
      default: state_n = RX_IDLE;
    endcase
  end

  // Frame datapath: sample counter, vote samples, shift register, error
  // accumulators. Everything per-frame is cleared while idle, which is
  // also what clears sc on the start detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sc_q       <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      v0_q       <= 1'b1;
      v1_q       <= 1'b1;
      shreg_q    <= '0;
      fe_acc_q   <= 1'b0;
      pe_acc_q   <= 1'b0;
    end else if (state_q == RX_IDLE) begin
      sc_q       <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      fe_acc_q   <= 1'b0;
      pe_acc_q   <= 1'b0;
    end else if (tick) begin
      sc_q <= sc_last ? '0 : sc_q + SCW'(1);
      if (sc_q == SCW'(MID - 1)) v0_q <= rxs;
      if (sc_q == SCW'(MID))     v1_q <= rxs;
      if (at_vote) begin
        case (state_q)
          RX_DATA:   shreg_q  <= {maj, shreg_q[DATA_BITS-1:1]};
          RX_PARITY: pe_acc_q <= par_bad;
          RX_STOP:   fe_acc_q <= fe_final;
          default: ;
        endcase
      end
      if (sc_last) begin
        case (state_q)
          RX_DATA: bit_cnt_q  <= bit_cnt_q + BCW'(1);
          RX_STOP: stop_cnt_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Holding register. A completion in the same cycle as an accept refills
  // the register directly, keeping rx_valid high.
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 fe_q;
  logic                 pe_q;
  logic                 overrun_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (done) begin
        if (!valid_q || rx.rx_ready) begin
          data_q  <= shreg_q;
          fe_q    <= fe_final;
          pe_q    <= pe_acc_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && rx.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx.rx_data    = data_q;
  assign rx.rx_valid   = valid_q;
  assign rx.frame_err  = fe_q;
  assign rx.parity_err = pe_q;
  assign rx.overrun    = overrun_q;
  assign busy          = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core
//   Bench for uart_rx_core: an 8N1 instance and an 8E1 instance driven by
//   bit-level serial stimulus. Delivered words are captured by monitors and
//   compared against a frame-level reference (data, stop value, parity rule).
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int OS       = 16;
  localparam int BIT      = 160;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rxd_n = 1'b1;
  logic rxd_e = 1'b1;
  logic busy_n;
  logic busy_e;

  always #5 clk = ~clk;

  uart_rx_core_if #(.DATA_BITS(8)) if_n ();
  uart_rx_core_if #(.DATA_BITS(8)) if_e ();

  uart_rx_core #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(1)
  ) dut_n (
    .clk(clk), .reset(reset), .rxd(rxd_n), .rx(if_n), .busy(busy_n)
  );

  uart_rx_core #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(8), .PARITY(PARITY_EVEN), .STOP_BITS(1)
  ) dut_e (
    .clk(clk), .reset(reset), .rxd(rxd_e), .rx(if_e), .busy(busy_e)
  );

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    int         cyc;
  } cap_t;

  typedef struct {
    bit         e;
    logic [7:0] d;
    logic       pbit;
    logic       stopv;
    logic [7:0] xd;
    logic       xfe;
    logic       xpe;
  } vec_t;

  cap_t q_n[$];
  cap_t q_e[$];
  int   cyc    = 0;
  int   ovr_n  = 0;
  int   ovr_e  = 0;
  int   checks = 0;
  int   failures = 0;
  int   stop_start = 0;

  function automatic cap_t mk(input logic [7:0] d, input logic fe, input logic pe, input int c);
    cap_t r;
    r.data = d; r.fe = fe; r.pe = pe; r.cyc = c;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && if_n.rx_valid && if_n.rx_ready)
      q_n.push_back(mk(if_n.rx_data, if_n.frame_err, if_n.parity_err, cyc));
  end
  always @(negedge clk) begin
    if (!reset && if_e.rx_valid && if_e.rx_ready)
      q_e.push_back(mk(if_e.rx_data, if_e.frame_err, if_e.parity_err, cyc));
  end
  always @(negedge clk) if (!reset && if_n.overrun) ovr_n <= ovr_n + 1;
  always @(negedge clk) if (!reset && if_e.overrun) ovr_e <= ovr_e + 1;

  initial begin
    #950_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_bits(input int n);
    repeat (n * BIT) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input bit e, input logic v);
    if (e) rxd_e = v;
    else   rxd_n = v;
  endtask

  // One frame: start, 8 data bits LSB first, parity (8E1 line only), stop.
  task automatic send_frame(input bit e, input logic [7:0] d, input logic pbit, input logic stopv);
    set_line(e, 1'b0);
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      set_line(e, d[i]);
      wait_bits(1);
    end
    if (e) begin
      set_line(e, pbit);
      wait_bits(1);
    end
    stop_start = cyc;
    set_line(e, stopv);
    wait_bits(1);
    set_line(e, 1'b1);
  endtask

  task automatic get_cap(input bit e, output cap_t c, output bit ok);
    ok = 1'b0;
    c  = mk(8'h00, 1'b0, 1'b0, 0);
    for (int i = 0; i < 2000 && !ok; i++) begin
      if ((e && q_e.size() > 0) || (!e && q_n.size() > 0)) ok = 1'b1;
      else @(negedge clk);
    end
    if (ok) begin
      if (e) c = q_e.pop_front();
      else   c = q_n.pop_front();
    end
  endtask

  task automatic chk_cap(input string name, input bit e, input logic [7:0] xd,
                         input logic xfe, input logic xpe);
    cap_t c;
    bit   ok;
    get_cap(e, c, ok);
    chk({name, " delivered"}, ok, 1);
    if (ok) begin
      chk({name, " data"},       c.data, xd);
      chk({name, " frame_err"},  c.fe,   xfe);
      chk({name, " parity_err"}, c.pe,   xpe);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " rx_data"},    if_n.rx_data,    0);
    chk({tag, " rx_valid"},   if_n.rx_valid,   0);
    chk({tag, " frame_err"},  if_n.frame_err,  0);
    chk({tag, " parity_err"}, if_n.parity_err, 0);
    chk({tag, " overrun"},    if_n.overrun,    0);
    chk({tag, " busy"},       busy_n,          0);
  endtask

  vec_t tv[7];

  initial begin
    logic [7:0] d;
    logic       p;
    logic       s;
    int         o0;
    cap_t       c;
    bit         ok;

    tv[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tv[1] = '{1'b1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1};
    tv[2] = '{1'b1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    tv[3] = '{1'b0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    tv[4] = '{1'b0, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0};
    tv[5] = '{1'b1, 8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    tv[6] = '{1'b1, 8'hC3, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b0};

    if_n.rx_ready = 1'b1;
    if_e.rx_ready = 1'b1;

    repeat (4) @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset busy_e", busy_e, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_bits(1);

    // Directed vectors.
    for (int i = 0; i < 7; i++) begin
      send_frame(tv[i].e, tv[i].d, tv[i].pbit, tv[i].stopv);
      wait_bits(2);
      if (i == 0) begin
        get_cap(1'b0, c, ok);
        chk("vec0 delivered", ok, 1);
        if (ok) begin
          chk("vec0 data", c.data, tv[0].xd);
          chk("vec0 frame_err", c.fe, tv[0].xfe);
          chk("vec0 parity_err", c.pe, tv[0].xpe);
          chk("vec0 valid latency", (c.cyc > stop_start) && (c.cyc - stop_start <= BIT), 1);
        end
      end else begin
        chk_cap($sformatf("vec%0d", i), tv[i].e, tv[i].xd, tv[i].xfe, tv[i].xpe);
      end
    end

    // Randomized frames on the even-parity line, judged by frame-level rules.
    for (int k = 0; k < 12; k++) begin
      d = 8'($urandom_range(0, 255));
      p = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 3) != 0);
      send_frame(1'b1, d, p, s);
      wait_bits(2);
      chk_cap($sformatf("rand%0d", k), 1'b1, d, !s, ((($countones(d) + int'(p)) % 2) != 0));
    end

    // False start: 60-clock low glitch.
    set_line(1'b0, 1'b0);
    repeat (30) @(posedge clk); #1;
    chk("glitch busy high", busy_n, 1);
    repeat (30) @(posedge clk); #1;
    set_line(1'b0, 1'b1);
    repeat (200) @(posedge clk); #1;
    chk("glitch busy low", busy_n, 0);
    chk("glitch no word", q_n.size(), 0);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b1);
    wait_bits(2);
    chk_cap("after glitch", 1'b0, 8'h3C, 1'b0, 1'b0);

    // Overrun with the consumer stalled.
    if_n.rx_ready = 1'b0;
    o0 = ovr_n;
    send_frame(1'b0, 8'h11, 1'b0, 1'b1);
    wait_bits(1);
    send_frame(1'b0, 8'h22, 1'b0, 1'b1);
    wait_bits(1);
    chk("ovr valid held", if_n.rx_valid, 1);
    chk("ovr data kept", if_n.rx_data, 8'h11);
    chk("ovr pulses", ovr_n - o0, 1);
    if_n.rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ovr valid falls", if_n.rx_valid, 0);
    chk_cap("ovr accept", 1'b0, 8'h11, 1'b0, 1'b0);
    wait_bits(2);
    chk("ovr no second word", q_n.size(), 0);

    // Break: line low for 15 bit times.
    set_line(1'b0, 1'b0);
    wait_bits(14);
    chk("break busy", busy_n, 1);
    chk("break one word", q_n.size(), 1);
    wait_bits(1);
    set_line(1'b0, 1'b1);
    wait_bits(1);
    chk("break exit busy", busy_n, 0);
    chk_cap("break word", 1'b0, 8'h00, 1'b1, 1'b0);
    send_frame(1'b0, 8'h55, 1'b0, 1'b1);
    wait_bits(2);
    chk_cap("after break", 1'b0, 8'h55, 1'b0, 1'b0);
    chk("after break extra", q_n.size(), 0);

    // Reset in the middle of the data bits of 0xFF.
    set_line(1'b0, 1'b0);
    wait_bits(1);
    set_line(1'b0, 1'b1);
    wait_bits(4);
    chk("midframe busy", busy_n, 1);
    reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk_reset_outputs("midreset");
    reset = 1'b0;
    wait_bits(8);
    chk("midreset no word", q_n.size(), 0);
    chk("midreset idle", busy_n, 0);
    send_frame(1'b0, 8'h81, 1'b0, 1'b1);
    wait_bits(2);
    chk_cap("after reset", 1'b0, 8'h81, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receiver: the successor to the fixed 8N1, 4x-oversampled receiver. It adds configurable data width, parity, stop bits and oversampling ratio, plus majority-vote sampling and false-start rejection. Received words are delivered through a one-entry valid/ready holding register with per-word error flags. It sits between the board RxD pin and the byte-stream consumers (command decoder, FIFO).

## Interface

- CLK_FREQ, 100_000_000: system clock in Hz
- BAUD_RATE, 9_600: line rate in baud
- OVERSAMPLE, 16: samples per bit; even, >= 4
- DATA_BITS, 8: data bits per frame, 5..9
- PARITY, 0: 0 none, 1 odd, 2 even
- STOP_BITS, 1: 1 or 2
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- rxd  in  1  asynchronous serial line, idle high
- rx_data  out  DATA_BITS  received word, LSB = first bit on the line
- rx_valid  out  1  rx_data and error flags are valid
- rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready
- frame_err  out  1  stop bit sampled 0; qualified by rx_valid
- parity_err  out  1  parity mismatch; qualified by rx_valid
- overrun  out  1  one-cycle pulse: a completed frame was dropped
- busy  out  1  state != IDLE

## Operation

- Input sync: 2-flop synchroniser on rxd. Both flops reset to 1. All logic uses the synchronised value `rxs`.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division.
  - Counter runs 0..DIV-1 and wraps. `tick` is high for 1 cycle at the wrap.
  - Free-running; cleared only by reset.
  - Elaboration error if DIV < 1, OVERSAMPLE is odd or < 4, or DATA_BITS is outside 5..9.
- Sample counter `sc`, 0..OVERSAMPLE-1, advances on tick. MID = OVERSAMPLE/2.
- Vote: samples at sc = MID-1, MID and MID+1. The majority of the three is resolved at the sc = MID+1 tick.
- States (encoded in the package):
  - IDLE: on a tick with rxs=0, clear sc and go to START.
  - START: at the vote, majority 1 means a false start and a return to IDLE with nothing delivered. Otherwise, at sc = OVERSAMPLE-1, go to DATA with bit count 0.
  - DATA: at the vote, shift the bit into bit DATA_BITS-1 of the shift register (shifting right). At sc = OVERSAMPLE-1, increment the bit count. After DATA_BITS bits, go to PARITY if PARITY != 0, else STOP.
  - PARITY: the vote gives `pbit`. Error condition: odd parity requires XOR(data, pbit) = 1; even parity requires it to be 0. At the end of the bit, go to STOP.
  - STOP: vote each stop bit. A 0 on any stop bit sets frame_err. The frame completes at the vote of the last stop bit, not at the end of that bit, to allow resync. Then:
    - go to BREAK if the data is all zeros and frame_err is set;
    - otherwise go to IDLE.
  - BREAK: wait for rxs=1, then go to IDLE. No new start is accepted while in BREAK.
- Completion (one cycle, `done`):
  - If the holding register is empty, or is being accepted this same cycle (rx_valid && rx_ready): load rx_data, frame_err and parity_err, and set rx_valid=1.
  - Otherwise: drop the frame, keep the old word, and pulse overrun.
- Handshake: rx_valid stays high until the cycle after rx_valid && rx_ready. rx_data and the flags are stable while rx_valid=1.
- Frames with frame_err or parity_err are still delivered.

## Timing

- Reset values: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0. State is IDLE, all counters 0, sync flops 1.
- Reset mid-frame aborts the frame immediately. No partial word is delivered.
- rx_valid rises on the clock edge after the tick that resolves the final stop-bit vote.
- Falling edge to detection latency: 2 sync cycles plus up to DIV cycles for tick alignment.
- Accept at cycle N: rx_valid=0 at N+1, unless a `done` also occurs at N. In that case the new word is presented at N+1 with rx_valid held at 1.
- No combinational path from rxd or rx_ready to any output.

## Structure

- Package `uart_pkg`:
  - `uart_rx_state_t` enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - Parity constants: PARITY_NONE, PARITY_ODD, PARITY_EVEN.
  - Function `uart_div(clk_freq, baud, os)`, shared with the future transmitter.
- Sub-module `uart_baud_tick`: parameter DIV; ports clk, reset, tick. Reused by the transmitter.
- Core FSM, vote logic and holding register live in `uart_rx_core`.

## Test plan

Bench parameters: CLK_FREQ=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16, so DIV=10 and 160 clocks per bit.

- 8N1, send 0xA5 -> one rx_valid with rx_data=0xA5, frame_err=0 and parity_err=0. Valid rises within 160 clocks after the start of the stop bit.
- PARITY=2 (even), send 0x07 with parity bit 0 -> rx_data=0x07, parity_err=1. Repeat with parity bit 1 -> parity_err=0.
- 60-clock low glitch on idle line -> false start, busy returns to 0, no rx_valid. A following 0x3C is received correctly.
- Hold rx_ready=0 and send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once at the second completion. Then raise rx_ready -> 0x11 is accepted and rx_valid falls.
- Line low for 15 bit times -> rx_data=0x00 with frame_err=1. No further frames until rxd returns high; a following 0x55 is received cleanly.
- Assert reset in the middle of the DATA bits of 0xFF -> all outputs return to reset values and no word is delivered. The next frame 0x81 is received correctly.
